// File: rtl/demux16_tdm.sv
// 16-lane TDM serial-to-parallel demultiplexer with frame resync.
// Define DEMUX16_TDM_MSB_FIRST_EN to land slot 0 in out[15] instead of out[0].
module demux16_tdm (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    input  logic        din_valid,
    input  logic        frame_start,
    output logic [15:0] out,
    output logic        out_valid,
    output logic [3:0]  slot,
    output logic        busy
);

    function automatic logic [3:0] lane_of(input logic [3:0] s);
`ifdef DEMUX16_TDM_MSB_FIRST_EN
        lane_of = 4'd15 - s;
`else
        lane_of = s;
`endif
    endfunction

    function automatic logic [15:0] place_bit(input logic b, input logic [3:0] lane);
        place_bit = {15'd0, b} << lane;
    endfunction

    logic [15:0] shadow_r;
    logic [15:0] out_r;
    logic [3:0]  slot_r;
    logic        out_valid_r;

    logic [15:0] shadow_wr_s;
    logic [15:0] restart_s;
    logic        last_s;

    // Next shadow contents for a normal write and for a resync write.
    always_comb begin
        shadow_wr_s = (shadow_r & ~place_bit(1'b1, lane_of(slot_r)))
                    | place_bit(din, lane_of(slot_r));
        last_s      = (slot_r == 4'd15);
        if (din_valid) begin
            restart_s = place_bit(din, lane_of(4'd0));
        end else begin
            restart_s = 16'd0;
        end
    end

    // Slot counter, shadow register and output lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r    <= 16'd0;
            out_r       <= 16'd0;
            slot_r      <= 4'd0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            if (frame_start) begin
                // Resync wins over a coincident completion; out is untouched.
                shadow_r <= restart_s;
                slot_r   <= din_valid ? 4'd1 : 4'd0;
            end else if (din_valid) begin
                if (last_s) begin
                    out_r       <= shadow_wr_s;
                    out_valid_r <= 1'b1;
                    shadow_r    <= 16'd0;
                    slot_r      <= 4'd0;
                end else begin
                    shadow_r <= shadow_wr_s;
                    slot_r   <= slot_r + 4'd1;
                end
            end else begin
                shadow_r <= shadow_r;
                slot_r   <= slot_r;
            end
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign slot      = slot_r;
    assign busy      = (slot_r != 4'd0);

endmodule

// File: tb/tb_demux16_tdm.sv
// Directed self-checking bench for demux16_tdm; expectations follow
// DEMUX16_TDM_MSB_FIRST_EN when it is defined for the build.
module tb_demux16_tdm;

    logic        clk;
    logic        rst;
    logic        din;
    logic        din_valid;
    logic        frame_start;
    logic [15:0] out;
    logic        out_valid;
    logic [3:0]  slot;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int cyc    = 0;

`ifdef DEMUX16_TDM_MSB_FIRST_EN
    localparam logic [15:0] EXP_STREAM = 16'hB0F1;
    localparam logic [15:0] EXP_RESYNC = 16'h8000;
    localparam logic [15:0] EXP_TOGGLE = 16'hC3A5;
    localparam logic [15:0] EXP_W0     = 16'hFF00;
    localparam logic [15:0] EXP_W1     = 16'h0F0F;
    localparam logic [15:0] EXP_W2     = 16'h3C3C;
`else
    localparam logic [15:0] EXP_STREAM = 16'h8F0D;
    localparam logic [15:0] EXP_RESYNC = 16'h0001;
    localparam logic [15:0] EXP_TOGGLE = 16'hA5C3;
    localparam logic [15:0] EXP_W0     = 16'h00FF;
    localparam logic [15:0] EXP_W1     = 16'hF0F0;
    localparam logic [15:0] EXP_W2     = 16'h3C3C;
`endif

    demux16_tdm dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_start(frame_start),
        .out        (out),
        .out_valid  (out_valid),
        .slot       (slot),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic tick(input logic r, input logic v, input logic fs, input logic d);
        rst         = r;
        din_valid   = v;
        frame_start = fs;
        din         = d;
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid === 1'b1) pulses++;
    endtask

    logic [15:0] words [3];
    logic [15:0] exps  [3];
    logic [15:0] tw;
    int seen;
    int prev;

    initial begin
        words = '{16'h00FF, 16'hF0F0, 16'h3C3C};
        exps  = '{EXP_W0, EXP_W1, EXP_W2};

        // Reset state
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_out", out, 16'h0000);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_slot", {12'd0, slot}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);

        // Scenario 1: 16-bit stream, checking mid-frame state and idle hold
        pulses = 0;
        tw = 16'h8F0D;
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 1'b0, tw[k]);
        check("s1_slot5", {12'd0, slot}, 16'd5);
        check("s1_busy", {15'd0, busy}, 16'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("s1_hold_slot", {12'd0, slot}, 16'd5);
        for (int k = 5; k < 15; k++) tick(1'b0, 1'b1, 1'b0, tw[k]);
        check("s1_no_early_pulse", {15'd0, out_valid}, 16'd0);
        check("s1_out_before", out, 16'h0000);
        tick(1'b0, 1'b1, 1'b0, tw[15]);
        check("s1_out_valid", {15'd0, out_valid}, 16'd1);
        check("s1_out", out, EXP_STREAM);
        check("s1_slot_wrap", {12'd0, slot}, 16'd0);
        check("s1_busy_wrap", {15'd0, busy}, 16'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("s1_pulse_len", {15'd0, out_valid}, 16'd0);
        check("s1_out_hold", out, EXP_STREAM);
        check("s1_pulses", pulses[15:0], 16'd1);

        // Scenario 2: resync after 8 bits, last resync coincides with nothing
        pulses = 0;
        for (int k = 0; k < 8; k++) tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        check("s2_resync_slot", {12'd0, slot}, 16'd1);
        check("s2_resync_out", out, EXP_STREAM);
        for (int k = 0; k < 15; k++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("s2_out", out, EXP_RESYNC);
        check("s2_pulses", pulses[15:0], 16'd1);

        // Scenario 2b: frame_start at slot 15 with a valid bit -> no completion
        pulses = 0;
        for (int k = 0; k < 15; k++) tick(1'b0, 1'b1, 1'b0, 1'b1);
        check("s2b_slot15", {12'd0, slot}, 16'd15);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        check("s2b_no_pulse", pulses[15:0], 16'd0);
        check("s2b_slot", {12'd0, slot}, 16'd1);
        check("s2b_out_hold", out, EXP_RESYNC);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("s2b_fs_idle_slot", {12'd0, slot}, 16'd0);

        // Scenario 3: partial frame, reset, then 16 ones
        pulses = 0;
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        check("s3_rst_out", out, 16'h0000);
        check("s3_rst_slot", {12'd0, slot}, 16'd0);
        for (int k = 0; k < 15; k++) tick(1'b0, 1'b1, 1'b0, 1'b1);
        check("s3_out_pre", out, 16'h0000);
        check("s3_slot15", {12'd0, slot}, 16'd15);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        check("s3_out", out, 16'hFFFF);
        check("s3_pulses", pulses[15:0], 16'd1);

        // Scenario 4: din_valid toggling, invalid cycles carry inverted junk
        pulses = 0;
        tw = 16'hA5C3;
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) tick(1'b0, 1'b1, 1'b0, tw[i / 2]);
            else            tick(1'b0, 1'b0, 1'b0, ~tw[i / 2]);
        end
        check("s4_out", out, EXP_TOGGLE);
        check("s4_pulses", pulses[15:0], 16'd1);

        // Scenario 5: 48 continuous valid cycles -> three frames
        pulses = 0;
        seen   = 0;
        prev   = 0;
        for (int i = 0; i < 48; i++) begin
            tw = words[i / 16];
            tick(1'b0, 1'b1, 1'b0, tw[i % 16]);
            if (out_valid === 1'b1) begin
                if (seen < 3) check("s5_out", out, exps[seen]);
                if (seen > 0) check("s5_spacing", 16'(cyc - prev), 16'd16);
                prev = cyc;
                seen++;
            end
        end
        check("s5_pulses", pulses[15:0], 16'd3);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("s5_tail_valid", {15'd0, out_valid}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
